operand_fetch: RTL and testbench

Master side of the register-file read interface. Takes one decoded instruction per cycle from decode, drives both `i_fetch_rreg` read ports, and resolves RAW hazards against the EX and MEM stages by forwarding or interlock. Registers the resolved operands into the ID/EX pipeline register with a valid/ready handshake toward EX. Also inserts load-use bubbles and honours pipeline flush.

---
 rtl/project_types.sv | 45 ++++
 rtl/i_fetch_rreg.sv | 13 +
 rtl/operand_mux.sv | 47 ++++
 rtl/operand_fetch.sv | 130 +++++++++++++
 tb/tb_operand_fetch.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/project_types.sv
// Shared register-file and operand-fetch types: register info/data, ALU ops,
// and the packed ID/EX output-register payload.
package project_types;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam logic REG_ENABLE = 1'b1;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } reg_info_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_t;

  // Payload of the ID/EX register; its valid bit travels separately.
  typedef struct packed {
    alu_op_t   op;
    logic [31:0] imm;
    reg_data_t src1;
    reg_data_t src2;
    reg_info_t dest;
    logic      is_load;
  } of_stage_t;

endpackage

// File: rtl/i_fetch_rreg.sv
// Two-port register-file read interface; the register file bypasses WB itself.
interface i_fetch_rreg;
  import project_types::*;

  reg_info_t r1_info;
  reg_info_t r2_info;
  reg_data_t r1_data;
  reg_data_t r2_data;

  modport master (output r1_info, output r2_info, input r1_data, input r2_data);
  modport slave  (input r1_info, input r2_info, output r1_data, output r2_data);

endinterface

// File: rtl/operand_mux.sv
// Per-operand source select and RAW hazard detection.
// OPERAND_FWD_EN: forward from EX/MEM and stall only on load-use; otherwise
// read the register file only and stall until the producer reaches WB.
module operand_mux
  import project_types::*;
(
  input  reg_info_t src,
  input  reg_t      ex_wreg,
  input  reg_t      mem_wreg,
  input  logic      ex_is_load,
  input  reg_info_t ex_dest,
  input  reg_data_t rf_data,
  output reg_data_t data,
  output logic      hazard
);

  logic src_live;
  logic ex_match;
  logic mem_match;

  // $0 and disabled sources never forward and never stall.
  assign src_live  = (src.en == REG_ENABLE) && (src.addr != '0);
  assign ex_match  = ex_dest.en && (ex_dest.addr == src.addr);
  assign mem_match = mem_wreg.en && (mem_wreg.addr == src.addr);

`ifdef OPERAND_FWD_EN
  always_comb begin
    data = rf_data;
    if (!src_live)
      data = '0;
    else if (ex_wreg.en && (ex_wreg.addr == src.addr) && !ex_is_load)
      data = ex_wreg.data;
    else if (mem_match)
      data = mem_wreg.data;
  end

  // Load data is not available until MEM, so a dependent op waits one cycle.
  assign hazard = src_live && ex_is_load && ex_match;
`else
  logic unused_fwd;

  assign data       = src_live ? rf_data : '0;
  assign hazard     = src_live && (ex_match || mem_match);
  assign unused_fwd = ^{ex_wreg, ex_is_load, mem_wreg.data};
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read master, RAW resolution and ID/EX register.
// Forwarding is compiled in when OPERAND_FWD_EN is defined.
module operand_fetch
  import project_types::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  reg_info_t              id_r1,
  input  reg_info_t              id_r2,
  input  reg_info_t              id_dest,
  input  logic                   id_is_load,
  input  alu_op_t                id_op,
  input  logic [31:0]            id_imm,
  i_fetch_rreg.master            read,
  input  reg_t                   ex_wreg,
  input  reg_t                   mem_wreg,
  input  logic                   flush,
  output logic                   of_valid,
  input  logic                   ex_ready,
  output alu_op_t                of_op,
  output logic [31:0]            of_imm,
  output reg_data_t              of_src1,
  output reg_data_t              of_src2,
  output reg_info_t              of_dest,
  output logic                   of_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  of_stage_t               of_p1;
  logic                    vld_p1;
  logic [STALL_CNT_W-1:0]  stall_cnt_p1;

  reg_data_t src1_sel;
  reg_data_t src2_sel;
  logic      hz1;
  logic      hz2;
  logic      hazard;
  logic      accept;
  logic      ex_is_load;
  reg_info_t ex_dest;

  assign read.r1_info = id_r1;
  assign read.r2_info = id_r2;

  // The output register is what EX is working on this cycle.
  assign ex_is_load = vld_p1 & of_p1.is_load;

  always_comb begin
    ex_dest      = of_p1.dest;
    ex_dest.en   = vld_p1 & of_p1.dest.en;
  end

  operand_mux u_mux_r1 (
    .src        (id_r1),
    .ex_wreg    (ex_wreg),
    .mem_wreg   (mem_wreg),
    .ex_is_load (ex_is_load),
    .ex_dest    (ex_dest),
    .rf_data    (read.r1_data),
    .data       (src1_sel),
    .hazard     (hz1)
  );

  operand_mux u_mux_r2 (
    .src        (id_r2),
    .ex_wreg    (ex_wreg),
    .mem_wreg   (mem_wreg),
    .ex_is_load (ex_is_load),
    .ex_dest    (ex_dest),
    .rf_data    (read.r2_data),
    .data       (src2_sel),
    .hazard     (hz2)
  );

  assign hazard = hz1 | hz2;

  // Flush wins: decode's current instruction is swallowed rather than stalled.
  assign id_ready = rst & (flush | (~hazard & (~vld_p1 | ex_ready)));
  assign accept   = id_valid & id_ready & ~flush;

  // ---- stage p1: ID/EX output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_p1 <= 1'b0;
    else if (flush)
      vld_p1 <= 1'b0;
    else if (accept)
      vld_p1 <= 1'b1;
    else if (ex_ready)
      vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      of_p1 <= '0;
    end else if (accept) begin
      of_p1.op      <= id_op;
      of_p1.imm     <= id_imm;
      of_p1.src1    <= src1_sel;
      of_p1.src2    <= src2_sel;
      of_p1.dest    <= id_dest;
      of_p1.is_load <= id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_p1 <= '0;
    else if (id_valid && !id_ready)
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign of_valid   = vld_p1;
  assign of_op      = of_p1.op;
  assign of_imm     = of_p1.imm;
  assign of_src1    = of_p1.src1;
  assign of_src2    = of_p1.src2;
  assign of_dest    = of_p1.dest;
  assign of_is_load = of_p1.is_load;
  assign stall_cnt  = stall_cnt_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a
// behavioural model of the forwarding/interlock rules.
module tb_operand_fetch;
  import project_types::*;

`ifdef OPERAND_FWD_EN
  localparam int EXF_STALLS = 0;
  localparam int LU_STALLS  = 1;
`else
  localparam int EXF_STALLS = 2;
  localparam int LU_STALLS  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  reg_info_t   id_r1, id_r2, id_dest;
  logic        id_is_load;
  alu_op_t     id_op;
  logic [31:0] id_imm;
  reg_t        ex_wreg, mem_wreg;
  logic        flush, ex_ready;

  logic        id_ready, of_valid, of_is_load;
  alu_op_t     of_op;
  logic [31:0] of_imm;
  reg_data_t   of_src1, of_src2;
  reg_info_t   of_dest;
  logic [31:0] stall_cnt;

  logic        id_ready4, of_valid4, unused_ld4;
  alu_op_t     unused_op4;
  logic [31:0] unused_imm4;
  reg_data_t   unused_s1_4, unused_s2_4;
  reg_info_t   unused_dest4;
  logic [3:0]  stall_cnt4;

  reg_data_t rf [32];

  i_fetch_rreg rd ();
  i_fetch_rreg rd4 ();
  assign rd.r1_data  = rf[rd.r1_info.addr];
  assign rd.r2_data  = rf[rd.r2_info.addr];
  assign rd4.r1_data = rf[rd4.r1_info.addr];
  assign rd4.r2_data = rf[rd4.r2_info.addr];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_r1(id_r1), .id_r2(id_r2), .id_dest(id_dest), .id_is_load(id_is_load),
    .id_op(id_op), .id_imm(id_imm), .read(rd), .ex_wreg(ex_wreg),
    .mem_wreg(mem_wreg), .flush(flush), .of_valid(of_valid), .ex_ready(ex_ready),
    .of_op(of_op), .of_imm(of_imm), .of_src1(of_src1), .of_src2(of_src2),
    .of_dest(of_dest), .of_is_load(of_is_load), .stall_cnt(stall_cnt)
  );

  operand_fetch #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready4),
    .id_r1(id_r1), .id_r2(id_r2), .id_dest(id_dest), .id_is_load(id_is_load),
    .id_op(id_op), .id_imm(id_imm), .read(rd4), .ex_wreg(ex_wreg),
    .mem_wreg(mem_wreg), .flush(flush), .of_valid(of_valid4), .ex_ready(ex_ready),
    .of_op(unused_op4), .of_imm(unused_imm4), .of_src1(unused_s1_4),
    .of_src2(unused_s2_4), .of_dest(unused_dest4), .of_is_load(unused_ld4),
    .stall_cnt(stall_cnt4)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: contents of the ID/EX register and the stall tally.
  logic        m_vld, m_is_load, m_acc;
  alu_op_t     m_op;
  logic [31:0] m_imm;
  reg_data_t   m_src1, m_src2;
  reg_info_t   m_dest;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic reg_info_t ri(input logic en, input int addr);
    reg_info_t r;
    r.en   = en;
    r.addr = 5'(addr);
    return r;
  endfunction

  function automatic reg_t rw(input logic en, input int addr, input logic [31:0] d);
    reg_t r;
    r.en   = en;
    r.addr = 5'(addr);
    r.data = d;
    return r;
  endfunction

  function automatic logic live(input reg_info_t s);
    return s.en && (s.addr != 0);
  endfunction

  function automatic logic src_hazard(input reg_info_t s);
    if (!live(s)) return 1'b0;
`ifdef OPERAND_FWD_EN
    return m_vld && m_is_load && m_dest.en && (m_dest.addr == s.addr);
`else
    return (m_vld && m_dest.en && (m_dest.addr == s.addr)) ||
           (mem_wreg.en && (mem_wreg.addr == s.addr));
`endif
  endfunction

  function automatic reg_data_t src_value(input reg_info_t s);
    if (!live(s)) return '0;
`ifdef OPERAND_FWD_EN
    if (ex_wreg.en && ex_wreg.addr == s.addr && !(m_vld && m_is_load)) return ex_wreg.data;
    if (mem_wreg.en && mem_wreg.addr == s.addr) return mem_wreg.data;
`endif
    return rf[s.addr];
  endfunction

  function automatic logic exp_ready();
    if (!rst) return 1'b0;
    if (flush) return 1'b1;
    return !(src_hazard(id_r1) || src_hazard(id_r2)) && (!m_vld || ex_ready);
  endfunction

  task automatic model_reset();
    m_vld = 0; m_is_load = 0; m_acc = 0; m_op = ALU_ADD; m_imm = 0;
    m_src1 = 0; m_src2 = 0; m_dest = '0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic rdy);
    reg_data_t s1, s2;
    s1 = src_value(id_r1);
    s2 = src_value(id_r2);
    m_acc = id_valid && rdy && !flush;
    if (id_valid && !rdy) m_cnt++;
    if (flush) m_vld = 0;
    else if (m_acc) begin
      m_vld = 1; m_op = id_op; m_imm = id_imm; m_src1 = s1; m_src2 = s2;
      m_dest = id_dest; m_is_load = id_is_load;
    end else if (ex_ready) m_vld = 0;
  endtask

  task automatic check_outputs();
    check_eq("of_valid",   64'(of_valid),   64'(m_vld));
    check_eq("of_valid4",  64'(of_valid4),  64'(m_vld));
    check_eq("of_op",      64'(of_op),      64'(m_op));
    check_eq("of_imm",     64'(of_imm),     64'(m_imm));
    check_eq("of_src1",    64'(of_src1),    64'(m_src1));
    check_eq("of_src2",    64'(of_src2),    64'(m_src2));
    check_eq("of_dest",    64'(of_dest),    64'(m_dest));
    check_eq("of_is_load", 64'(of_is_load), 64'(m_is_load));
    check_eq("stall_cnt",  64'(stall_cnt),  64'(m_cnt));
    check_eq("stall_cnt4", 64'(stall_cnt4), 64'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    logic rdy;
    #1;
    rdy = exp_ready();
    check_eq("id_ready",  64'(id_ready),  64'(rdy));
    check_eq("id_ready4", 64'(id_ready4), 64'(rdy));
    check_eq("r1_info",   64'(rd.r1_info), 64'(id_r1));
    check_eq("r2_info",   64'(rd.r2_info), 64'(id_r2));
    @(posedge clk);
    model_edge(rdy);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic present(input logic v, input reg_info_t a, input reg_info_t b,
                         input reg_info_t d, input logic ld, input logic [31:0] imm);
    id_valid = v; id_r1 = a; id_r2 = b; id_dest = d; id_is_load = ld; id_imm = imm;
    id_op = alu_op_t'(4'($urandom_range(0, 7)));
  endtask

  task automatic env(input reg_t ex, input reg_t mem, input logic exr, input logic fl);
    ex_wreg = ex; mem_wreg = mem; ex_ready = exr; flush = fl;
  endtask

  initial begin
    int unsigned base;
    reg_t off;
    off = rw(0, 0, 0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 5; rf[2] = 7; rf[3] = 32'h55; rf[4] = 11; rf[5] = 13; rf[8] = 32'h1;
    rst = 0;
    present(0, '0, '0, '0, 0, 0);
    env(off, off, 1, 0);
    model_reset();
    #1;
    check_eq("rst_id_ready",  64'(id_ready),   64'(0));
    check_eq("rst_of_valid",  64'(of_valid),   64'(0));
    check_eq("rst_of_src1",   64'(of_src1),    64'(0));
    check_eq("rst_stall_cnt", 64'(stall_cnt),  64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // Independent stream.
    present(1, ri(1, 1), ri(1, 2), ri(1, 3), 0, 32'h10);
    step();
    check_eq("indep_src1", 64'(of_src1), 64'(5));
    check_eq("indep_src2", 64'(of_src2), 64'(7));
    present(1, ri(1, 4), ri(1, 5), ri(1, 6), 0, 32'h11);
    step();
    check_eq("indep2_src1", 64'(of_src1), 64'(11));
    check_eq("indep_stalls", 64'(stall_cnt), 64'(0));
    present(1, ri(1, 1), ri(1, 2), ri(1, 3), 0, 32'h12);
    step();

    // EX result feeding the next instruction.
    base = m_cnt;
    for (int k = 0; k < 4; k++) begin
      present(1, ri(1, 3), ri(0, 0), ri(0, 0), 0, 32'h20);
      if (k == 0) env(rw(1, 3, 32'h1234), off, 1, 0);
      else if (k == 1) env(off, rw(1, 3, 32'h1234), 1, 0);
      else begin env(off, off, 1, 0); rf[3] = 32'h1234; end
      step();
      if (m_acc) break;
    end
    check_eq("exfwd_src1", 64'(of_src1), 64'(32'h1234));
    check_eq("exfwd_stalls", 64'(stall_cnt), 64'(base + EXF_STALLS));

    // Load followed by a dependent instruction.
    present(1, ri(0, 0), ri(0, 0), ri(1, 8), 1, 32'h30);
    env(off, off, 1, 0);
    step();
    base = m_cnt;
    for (int k = 0; k < 4; k++) begin
      present(1, ri(1, 8), ri(0, 0), ri(0, 0), 0, 32'h31);
      if (k == 0) env(rw(1, 8, 32'hDEAD), off, 1, 0);
      else if (k == 1) env(off, rw(1, 8, 32'hCAFE), 1, 0);
      else begin env(off, off, 1, 0); rf[8] = 32'hCAFE; end
      step();
      if (k == 0) check_eq("lu_bubble", 64'(of_valid), 64'(0));
      if (m_acc) break;
    end
    check_eq("lu_src1", 64'(of_src1), 64'(32'hCAFE));
    check_eq("lu_stalls", 64'(stall_cnt), 64'(base + LU_STALLS));

    // $0 sources ignore any producer targeting $0.
    present(1, ri(1, 0), ri(1, 0), ri(0, 0), 0, 32'h40);
    env(rw(1, 0, 32'hFFFF), rw(1, 0, 32'hFFFF), 1, 0);
    step();
    check_eq("zero_src1", 64'(of_src1), 64'(0));
    check_eq("zero_src2", 64'(of_src2), 64'(0));

    // Backpressure, then flush.
    present(1, ri(1, 1), ri(0, 0), ri(1, 9), 0, 32'h50);
    env(off, off, 1, 0);
    step();
    base = m_cnt;
    present(1, ri(0, 0), ri(0, 0), ri(1, 10), 0, 32'h51);
    env(off, off, 0, 0);
    repeat (3) step();
    check_eq("bp_imm", 64'(of_imm), 64'(32'h50));
    check_eq("bp_stalls", 64'(stall_cnt), 64'(base + 3));
    env(off, off, 1, 1);
    step();
    check_eq("flush_valid", 64'(of_valid), 64'(0));
    env(off, off, 1, 0);
    present(0, '0, '0, '0, 0, 0);
    step();

    // Asynchronous reset in the middle of a stall.
    present(1, ri(1, 2), ri(0, 0), ri(1, 11), 0, 32'h60);
    step();
    present(1, ri(0, 0), ri(0, 0), ri(0, 0), 0, 32'h61);
    env(off, off, 0, 0);
    step();
    #2 rst = 0;
    #1;
    check_eq("arst_id_ready",  64'(id_ready),  64'(0));
    check_eq("arst_of_valid",  64'(of_valid),  64'(0));
    check_eq("arst_of_imm",    64'(of_imm),    64'(0));
    check_eq("arst_of_src1",   64'(of_src1),   64'(0));
    check_eq("arst_stall_cnt", 64'(stall_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1;

    // Long stall saturates the narrow counter.
    present(1, ri(0, 0), ri(0, 0), ri(0, 0), 0, 32'h70);
    env(off, off, 1, 0);
    step();
    present(1, ri(0, 0), ri(0, 0), ri(0, 0), 0, 32'h71);
    env(off, off, 0, 0);
    repeat (20) step();
    check_eq("sat_cnt32", 64'(stall_cnt),  64'(20));
    check_eq("sat_cnt4",  64'(stall_cnt4), 64'(15));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reg_info_t a, b, d;
      a = ri(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      b = ri(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      d = ri(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      present(1'($urandom_range(0, 4) != 0), a, b, d, 1'($urandom_range(0, 3) == 0), $urandom);
      env(rw(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom),
          rw(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 4)] = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
